// File: rtl/aes_pkg.sv
// Shared AES definitions for the streaming round-key datapath: FSM encodings,
// word types, rcon handling and the NK legality check.
package aes_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] col_t;
    typedef logic [1:0]  fsm_t;

    localparam fsm_t ST_NOKEY = 2'd0;
    localparam fsm_t ST_READY = 2'd1;
    localparam fsm_t ST_BUSY  = 2'd2;
    localparam fsm_t ST_DONE  = 2'd3;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic bit nk_legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational SubWord: four AES S-box lookups, each computed as the GF(2^8)
// inverse followed by the affine transform instead of a 256-entry table.
module sub_word
    import aes_pkg::*;
(
    input  word_t word_in,
    output word_t word_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        t   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t   = gf_mul(t, t);
            inv = gf_mul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign word_out[8*gi +: 8] = sbox(word_in[8*gi +: 8]);
    end

endmodule

// File: rtl/round_key_stream.sv
// AddRoundKey with on-the-fly key expansion: one expanded word is produced and
// XORed into one state column per cycle, so no key schedule is stored.
module round_key_stream
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [32*NK-1:0]  key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      state_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      state_out,
    output logic [3:0]        round_out
);

    localparam int NR = NK + 6;
    localparam logic [3:0] NR_W    = 4'(NR);
    localparam logic [5:0] NK_W    = 6'(NK);
    localparam logic [2:0] PH_LAST = 3'(NK - 1);

    if (!nk_legal(NK)) begin : g_nk_check
        $error("round_key_stream: NK must be 4, 6 or 8");
    end

    fsm_t         fsm_reg;
    word_t        key_reg [NK];
    word_t        win_reg [NK];
    logic [5:0]   idx_reg;
    logic [2:0]   phase_reg;
    logic [7:0]   rcon_reg;
    logic [1:0]   col_reg;
    logic [127:0] data_reg;
    logic [3:0]   round_reg;

    word_t key_words [NK];
    word_t sub_in;
    word_t sub_out;
    word_t new_w;

    for (genvar gi = 0; gi < NK; gi++) begin : g_key_words
        assign key_words[gi] = key_in[32*(NK-gi)-1 -: 32];
    end

    // win_reg[0] is w[i-NK], win_reg[NK-1] is w[i-1]. Seeding the window with
    // the key and rotating it lets the first NK words fall out of win_reg[0].
    assign sub_in = (phase_reg == 3'd0) ? rot_word(win_reg[NK-1]) : win_reg[NK-1];

    sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        new_w = win_reg[0] ^ win_reg[NK-1];
        if (idx_reg < NK_W) begin
            new_w = win_reg[0];
        end else if (phase_reg == 3'd0) begin
            new_w = win_reg[0] ^ sub_out ^ {rcon_reg, 24'h000000};
        end else if ((NK == 8) && (phase_reg == 3'd4)) begin
            new_w = win_reg[0] ^ sub_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg   <= ST_NOKEY;
            idx_reg   <= '0;
            phase_reg <= '0;
            rcon_reg  <= RCON_INIT;
            col_reg   <= '0;
            data_reg  <= '0;
            round_reg <= '0;
            for (int k = 0; k < NK; k++) begin
                key_reg[k] <= '0;
                win_reg[k] <= '0;
            end
        end else if (key_load) begin
            fsm_reg   <= ST_READY;
            idx_reg   <= '0;
            phase_reg <= '0;
            rcon_reg  <= RCON_INIT;
            col_reg   <= '0;
            round_reg <= '0;
            for (int k = 0; k < NK; k++) begin
                key_reg[k] <= key_words[k];
                win_reg[k] <= key_words[k];
            end
        end else begin
            case (fsm_reg)
                ST_READY: begin
                    if (in_valid) begin
                        data_reg <= state_in;
                        col_reg  <= '0;
                        fsm_reg  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    data_reg <= data_reg ^ ({new_w, 96'h0} >> {col_reg, 5'b00000});
                    for (int k = 0; k < NK - 1; k++) begin
                        win_reg[k] <= win_reg[k+1];
                    end
                    win_reg[NK-1] <= new_w;
                    idx_reg       <= idx_reg + 6'd1;
                    phase_reg     <= (phase_reg == PH_LAST) ? 3'd0 : phase_reg + 3'd1;
                    if ((idx_reg >= NK_W) && (phase_reg == 3'd0)) begin
                        rcon_reg <= xtime(rcon_reg);
                    end
                    col_reg <= col_reg + 2'd1;
                    if (col_reg == 2'd3) begin
                        fsm_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_reg <= ST_READY;
                        if (round_reg == NR_W) begin
                            // Schedule restarts from the latched key after the last round.
                            round_reg <= '0;
                            idx_reg   <= '0;
                            phase_reg <= '0;
                            rcon_reg  <= RCON_INIT;
                            for (int k = 0; k < NK; k++) begin
                                win_reg[k] <= key_reg[k];
                            end
                        end else begin
                            round_reg <= round_reg + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (fsm_reg == ST_READY);
    assign out_valid = (fsm_reg == ST_DONE);
    assign state_out = data_reg;
    assign round_out = round_reg;

endmodule
